// File: rtl/seven_seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared types and helpers for the seven-segment scan driver.
//   - seg_t        : active-high segment vector {a,b,c,d,e,f,g}, bit6 = a
//   - SEG_BLANK    : all segments off (active-high form)
//   - scan_state_t : scan FSM states OFF / GUARD / DRIVE
//   - bcd_to_seg   : BCD digit to active-high segments, 10..15 -> SEG_BLANK
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b000_0000;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Standard common-anode glyphs, expressed active-high; the top inverts.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = 7'b111_1110;
      4'd1:    seg = 7'b011_0000;
      4'd2:    seg = 7'b110_1101;
      4'd3:    seg = 7'b111_1001;
      4'd4:    seg = 7'b011_0011;
      4'd5:    seg = 7'b101_1011;
      4'd6:    seg = 7'b101_1111;
      4'd7:    seg = 7'b111_0000;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b111_1011;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
//   Bundles the BCD source side and the display pin side of the scan driver.
//   Ports carried:
//     en_in       1 = scan, 0 = dark
//     digits_in   4*N_DIGITS BCD digits, digit 0 rightmost
//     dp_in       N_DIGITS decimal points, active-high
//     seg_n       7 segments {a..g}, active-low
//     dp_n        decimal point, active-low
//     an_n        N_DIGITS anode selects, active-low
//     frame_tick  1-cycle pulse on each frame snapshot
//   Modports: master = source/board side, slave = the driver.
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    en_in;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [N_DIGITS-1:0]     an_n;
  logic                    frame_tick;

  modport master (
    output en_in, digits_in, dp_in,
    input  seg_n, dp_n, an_n, frame_tick
  );

  modport slave (
    input  en_in, digits_in, dp_in,
    output seg_n, dp_n, an_n, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_driver_scan_slot_timer.sv
// -----------------------------------------------------------------------------
// scan_slot_timer
//   Owns the per-slot cycle counter (div_cnt). While run is high it counts
//   0..CLK_DIV-1 and wraps; while run is low it is held at 0 so that every
//   (re)start begins a fresh slot.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     run          1 = scanning (FSM in GUARD/DRIVE and still enabled)
//     guard_done   strobe on the last guard cycle of a slot
//     slot_done    strobe on the last cycle of a slot
// -----------------------------------------------------------------------------
module scan_slot_timer #(
  parameter int CLK_DIV      = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic guard_done,
  output logic slot_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  // Next count: hold at zero when idle, wrap at the end of each slot.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == SLOT_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Strobes are decoded from the registered count, so they carry no input path
  // except the run qualifier.
  assign guard_done = run && (div_cnt_q == GUARD_LAST);
  assign slot_done  = run && (div_cnt_q == SLOT_LAST);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexes N_DIGITS BCD digits onto one common-anode 7-segment bus.
//   Each digit slot lasts CLK_DIV cycles: GUARD_CYCLES with every anode off
//   (anti-ghosting), then the remainder with that digit's anode on. The digit
//   values are snapshotted at the start of every frame so a frame never tears.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   seven_seg_scan_driver_if.slave
//             en_in, digits_in, dp_in  -> inputs
//             seg_n, dp_n, an_n, frame_tick -> registered outputs
//   Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//     When defined, leading zeros (digit i>0 with it and all higher digits 0)
//     are blanked: anode stays off, segments and dp stay dark. Slot timing is
//     unchanged. When undefined, every digit is shown.
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  scan_state_t                 state_q;
  scan_state_t                 state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            idx_d;
  logic [N_DIGITS-1:0][3:0]    digit_q;
  logic [N_DIGITS-1:0][3:0]    digit_d;
  logic [N_DIGITS-1:0]         dpf_q;
  logic [N_DIGITS-1:0]         dpf_d;

  logic [N_DIGITS-1:0]         an_n_q;
  logic [N_DIGITS-1:0]         an_n_d;
  logic [6:0]                  seg_n_q;
  logic [6:0]                  seg_n_d;
  logic                        dp_n_q;
  logic                        dp_n_d;
  logic                        frame_tick_q;
  logic                        frame_tick_d;

  logic                        run_s;
  logic                        guard_done_s;
  logic                        slot_done_s;
  logic                        snap_s;
  logic [N_DIGITS-1:0]         blank_s;
  logic [3:0]                  cur_digit_s;
  logic                        cur_dp_s;
  logic                        cur_blank_s;

  // The timer only runs while scanning; dropping en_in clears it the same edge
  // the FSM falls back to OFF.
  assign run_s = bus.en_in && (state_q != OFF);

  scan_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run_s),
    .guard_done (guard_done_s),
    .slot_done  (slot_done_s)
  );

  // Scan FSM next state, digit index, and snapshot request.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_s  = 1'b0;
    if (!bus.en_in) begin
      state_d = OFF;
      idx_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = GUARD;
          idx_d   = '0;
          snap_s  = 1'b1;
        end
        GUARD: begin
          if (guard_done_s) begin
            state_d = DRIVE;
          end else begin
            state_d = GUARD;
          end
        end
        DRIVE: begin
          if (slot_done_s) begin
            state_d = GUARD;
            // Wrapping back to digit 0 starts a new frame, hence a new snapshot.
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              snap_s = 1'b1;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              snap_s = 1'b0;
            end
          end else begin
            state_d = DRIVE;
          end
        end
        default: begin
          state_d = OFF;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Frame snapshot: capture inputs only at the start of a frame.
  always_comb begin
    if (snap_s) begin
      digit_d = bus.digits_in;
      dpf_d   = bus.dp_in;
    end else begin
      digit_d = digit_q;
      dpf_d   = dpf_q;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Leading-zero mask over the frame being displayed, scanned from the most
  // significant digit down; digit 0 is never blanked.
  always_comb begin
    logic higher_zero;
    blank_s     = '0;
    higher_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (digit_d[i] == 4'd0);
      if (i > 0) begin
        blank_s[i] = higher_zero;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end
`else
  // No blanking: every digit is shown, leading zeros included.
  always_comb begin
    blank_s = '0;
  end
`endif

  assign cur_digit_s = digit_d[idx_d];
  assign cur_dp_s    = dpf_d[idx_d];
  assign cur_blank_s = blank_s[idx_d];

  // Output decode from the next state so the registered pins line up with the
  // state they describe; segments are already valid during the guard gap.
  always_comb begin
    an_n_d       = {N_DIGITS{1'b1}};
    seg_n_d      = 7'h7F;
    dp_n_d       = 1'b1;
    frame_tick_d = snap_s;
    case (state_d)
      OFF: begin
        an_n_d  = {N_DIGITS{1'b1}};
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
      end
      GUARD: begin
        if (cur_blank_s) begin
          seg_n_d = 7'h7F;
          dp_n_d  = 1'b1;
        end else begin
          seg_n_d = ~bcd_to_seg(cur_digit_s);
          dp_n_d  = ~cur_dp_s;
        end
      end
      DRIVE: begin
        if (cur_blank_s) begin
          seg_n_d = 7'h7F;
          dp_n_d  = 1'b1;
        end else begin
          seg_n_d        = ~bcd_to_seg(cur_digit_s);
          dp_n_d         = ~cur_dp_s;
          an_n_d[idx_d]  = 1'b0;
        end
      end
      default: begin
        an_n_d  = {N_DIGITS{1'b1}};
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
      end
    endcase
  end

  // State, index, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      idx_q        <= '0;
      digit_q      <= '0;
      dpf_q        <= '0;
      an_n_q       <= {N_DIGITS{1'b1}};
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      digit_q      <= digit_d;
      dpf_q        <= dpf_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//   Self-checking bench for seven_seg_scan_driver (N_DIGITS=4, CLK_DIV=8,
//   GUARD_CYCLES=2). The reference model tracks only "cycles since scanning
//   started" plus a snapshot of the digits, and derives slot, guard phase and
//   pins from that time with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int CD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = N * CD;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.N_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .N_DIGITS     (N),
    .CLK_DIV      (CD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_on;
  int         m_t;
  logic [3:0] m_dig [N];
  logic       m_dp  [N];
  bit         m_tick;

  // Active-high glyphs for digits 0..9, {a,b,c,d,e,f,g}
  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic take_snapshot();
    for (int i = 0; i < N; i++) begin
      m_dig[i] = bus.digits_in[4*i +: 4];
      m_dp[i]  = bus.dp_in[i];
    end
  endtask

  // Advance the model with the inputs present before the edge, clock once,
  // then return what the pins must show now.
  task automatic step(output logic [N-1:0] e_an, output logic [6:0] e_seg,
                      output logic e_dp, output logic e_tick);
    int slot;
    int pos;
    bit blank;
    if (rst) begin
      m_on = 1'b0; m_t = 0; m_tick = 1'b0;
      for (int i = 0; i < N; i++) begin m_dig[i] = 4'd0; m_dp[i] = 1'b0; end
    end else if (!bus.en_in) begin
      m_on = 1'b0; m_tick = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1; m_t = 0; take_snapshot(); m_tick = 1'b1;
    end else begin
      m_t = m_t + 1;
      if (m_t % FRAME == 0) begin take_snapshot(); m_tick = 1'b1; end
      else m_tick = 1'b0;
    end
    @(posedge clk);
    #1;
    e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_tick = m_tick;
    if (m_on) begin
      slot  = (m_t / CD) % N;
      pos   = m_t % CD;
      blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (slot > 0) begin
        blank = 1'b1;
        for (int j = slot; j < N; j++) if (m_dig[j] != 4'd0) blank = 1'b0;
      end
`endif
      if (!blank) begin
        if (m_dig[slot] < 4'd10) e_seg = ~ref_glyph(int'(m_dig[slot]));
        e_dp = ~m_dp[slot];
        if (pos >= GC) e_an[slot] = 1'b0;
      end
    end
  endtask

  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp;
  logic         e_tick;

  task automatic test_reset();
    rst = 1'b1; bus.en_in = 1'b1; bus.digits_in = 16'h5678; bus.dp_in = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset c=%0d got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
                 c, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick);
      end
    end
    bus.en_in = 1'b0;
    rst = 1'b0;
    step(e_an, e_seg, e_dp, e_tick);
    total++;
    if (bus.an_n !== 4'b1111 || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got an=%b tick=%b want an=1111 tick=0", bus.an_n, bus.frame_tick);
    end
  endtask

  task automatic test_basic_scan();
    bus.digits_in = 16'h1234; bus.dp_in = 4'b0001; bus.en_in = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL basic c=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 c, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      if (c == 0 || c == FRAME) begin
        total++;
        if (bus.frame_tick !== 1'b1 || bus.an_n !== 4'b1111) begin
          bad++;
          $display("FAIL basic_tick c=%0d got tick=%b an=%b want tick=1 an=1111", c, bus.frame_tick, bus.an_n);
        end
      end
      if (c == 2) begin
        total++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {4'b1110, 7'b1001100, 1'b0}) begin
          bad++;
          $display("FAIL basic_d0 got an=%b seg=%b dp=%b want an=1110 seg=1001100 dp=0", bus.an_n, bus.seg_n, bus.dp_n);
        end
      end
      if (c == CD + GC) begin
        total++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {4'b1101, 7'b0000110, 1'b1}) begin
          bad++;
          $display("FAIL basic_d1 got an=%b seg=%b dp=%b want an=1101 seg=0000110 dp=1", bus.an_n, bus.seg_n, bus.dp_n);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int k;
    k = 0;
    while (k < 100 && !(m_on && (m_t % FRAME) == CD + 3)) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL snap_pre got an=%b seg=%b want an=%b seg=%b", bus.an_n, bus.seg_n, e_an, e_seg);
      end
      k++;
    end
    total++;
    if (k >= 100) begin
      bad++;
      $display("FAIL snap_reach got cycles=%0d want <100", k);
    end
    bus.digits_in = 16'h9999;
    while ((m_t % FRAME) != FRAME - 1) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL snap_hold t=%0d got an=%b seg=%b want an=%b seg=%b", m_t, bus.an_n, bus.seg_n, e_an, e_seg);
      end
      if ((m_t % FRAME) == 2 * CD + GC) begin
        total++;
        if ({bus.an_n, bus.seg_n} !== {4'b1011, 7'b0010010}) begin
          bad++;
          $display("FAIL snap_d2 got an=%b seg=%b want an=1011 seg=0010010", bus.an_n, bus.seg_n);
        end
      end
      if ((m_t % FRAME) == 3 * CD + GC) begin
        total++;
        if ({bus.an_n, bus.seg_n} !== {4'b0111, 7'b1001111}) begin
          bad++;
          $display("FAIL snap_d3 got an=%b seg=%b want an=0111 seg=1001111", bus.an_n, bus.seg_n);
        end
      end
    end
    step(e_an, e_seg, e_dp, e_tick);
    total++;
    if ({bus.frame_tick, bus.seg_n} !== {1'b1, 7'b0000100}) begin
      bad++;
      $display("FAIL snap_new got tick=%b seg=%b want tick=1 seg=0000100", bus.frame_tick, bus.seg_n);
    end
  endtask

  task automatic test_invalid_bcd();
    bus.en_in = 1'b0;
    step(e_an, e_seg, e_dp, e_tick);
    bus.digits_in = 16'h00A0; bus.dp_in = 4'b0010; bus.en_in = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL invalid c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 c, bus.an_n, bus.seg_n, bus.dp_n, e_an, e_seg, e_dp);
      end
`ifndef SEG_LEADING_ZERO_BLANK_EN
      if (c == CD + GC) begin
        total++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {4'b1101, 7'h7F, 1'b0}) begin
          bad++;
          $display("FAIL invalid_d1 got an=%b seg=%b dp=%b want an=1101 seg=1111111 dp=0", bus.an_n, bus.seg_n, bus.dp_n);
        end
      end
`endif
    end
  endtask

  task automatic test_enable_drop();
    int k;
    bus.digits_in = 16'h1234; bus.dp_in = 4'b0000;
    k = 0;
    while (k < 100 && !(m_on && (m_t % FRAME) == 2 * CD + 4)) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL drop_pre got an=%b seg=%b want an=%b seg=%b", bus.an_n, bus.seg_n, e_an, e_seg);
      end
      k++;
    end
    total++;
    if (k >= 100) begin
      bad++;
      $display("FAIL drop_reach got cycles=%0d want <100", k);
    end
    bus.en_in = 1'b0;
    step(e_an, e_seg, e_dp, e_tick);
    total++;
    if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL drop_off got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
               bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick);
    end
    bus.en_in = 1'b1;
    step(e_an, e_seg, e_dp, e_tick);
    total++;
    if ({bus.frame_tick, bus.an_n} !== {1'b1, 4'b1111}) begin
      bad++;
      $display("FAIL drop_restart got tick=%b an=%b want tick=1 an=1111", bus.frame_tick, bus.an_n);
    end
    step(e_an, e_seg, e_dp, e_tick);
    step(e_an, e_seg, e_dp, e_tick);
    total++;
    if ({bus.an_n, bus.seg_n} !== {4'b1110, 7'b1001100}) begin
      bad++;
      $display("FAIL drop_d0 got an=%b seg=%b want an=1110 seg=1001100", bus.an_n, bus.seg_n);
    end
  endtask

  task automatic test_leading_zero();
    bus.en_in = 1'b0;
    step(e_an, e_seg, e_dp, e_tick);
    bus.digits_in = 16'h0050; bus.dp_in = 4'b1111; bus.en_in = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL lz c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 c, bus.an_n, bus.seg_n, bus.dp_n, e_an, e_seg, e_dp);
      end
      if (c == CD + GC) begin
        total++;
        if ({bus.an_n, bus.seg_n} !== {4'b1101, 7'b0100100}) begin
          bad++;
          $display("FAIL lz_d1 got an=%b seg=%b want an=1101 seg=0100100", bus.an_n, bus.seg_n);
        end
      end
      if (c == 3 * CD + GC) begin
        total++;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {4'b1111, 7'h7F, 1'b1}) begin
          bad++;
          $display("FAIL lz_d3 got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", bus.an_n, bus.seg_n, bus.dp_n);
        end
`else
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {4'b0111, 7'b0000001, 1'b0}) begin
          bad++;
          $display("FAIL lz_d3 got an=%b seg=%b dp=%b want an=0111 seg=0000001 dp=0", bus.an_n, bus.seg_n, bus.dp_n);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        mask = 16'hFFFF >> (4 * $urandom_range(0, 3));
        bus.digits_in = 16'($urandom) & mask;
        bus.dp_in     = 4'($urandom);
      end
      bus.en_in = ($urandom_range(0, 59) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step(e_an, e_seg, e_dp, e_tick);
      total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        bad++;
        $display("FAIL random c=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 c, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick, e_an, e_seg, e_dp, e_tick);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.en_in = 1'b0;
    bus.digits_in = 16'h0000;
    bus.dp_in = 4'b0000;
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_invalid_bcd();
    test_enable_drop();
    test_leading_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
